// File: rtl/alu_arb_if.sv
// alu_arb_if: bundle of the two requester channels and the shared-ALU port
// used by alu_arb. The slave modport is the arbiter's view; the master
// modport is the surrounding environment (requesters plus ALU).
interface alu_arb_if #(
  parameter int SIZE = 32
);
  // Requester side: both requesters packed side by side, requester i at slot i
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*SIZE-1:0] req_a;
  logic [2*SIZE-1:0] req_b;
  logic [7:0]        req_op;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [SIZE-1:0]   rsp_result;
  logic              rsp_zero;

  // Shared ALU side: registered operands out, combinational result back
  logic [SIZE-1:0]   alu_a;
  logic [SIZE-1:0]   alu_b;
  logic [3:0]        alu_operation;
  logic [SIZE-1:0]   alu_result;
  logic              alu_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_zero, alu_a, alu_b, alu_operation
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, alu_a, alu_b, alu_operation
  );
endinterface

// File: rtl/alu_arb.sv
// alu_arb: two-requester front end for one shared combinational ALU.
// One operation in flight at a time: IDLE (grant) -> EXEC (ALU settles)
// -> RESP (hold result until the owner consumes it).
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// wins every tie); leave it undefined for round-robin arbitration.
module alu_arb #(
  parameter int SIZE = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  alu_arb_if.slave  bus_if
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic [SIZE-1:0] alu_a_q, alu_a_d;
  logic [SIZE-1:0] alu_b_q, alu_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [SIZE-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic            last_q, last_d;
`endif

  logic            grant;
  logic [1:0]      req_ready;
  logic            handshake;

  // Pick the requester that would be served if a handshake happens now
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    grant = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant = ~bus_if.req_valid[0];
`else
    if (&bus_if.req_valid) grant = ~last_q;
    else                   grant = bus_if.req_valid[1];
`endif
  end

  // Only IDLE accepts, only one bit at a time, never while reset is held
  assign req_ready = (state_q == IDLE && !rst_i && (|bus_if.req_valid))
                   ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign handshake = |req_ready;

  // Next-state and datapath capture
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (handshake) begin
          alu_a_d  = grant ? bus_if.req_a[2*SIZE-1:SIZE] : bus_if.req_a[SIZE-1:0];
          alu_b_d  = grant ? bus_if.req_b[2*SIZE-1:SIZE] : bus_if.req_b[SIZE-1:0];
          alu_op_d = grant ? bus_if.req_op[7:4] : bus_if.req_op[3:0];
          owner_d  = grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d   = grant;
`endif
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = bus_if.alu_result;
        rsp_zero_d   = bus_if.alu_zero;
        state_d      = RESP;
      end
      RESP: begin
        if (bus_if.rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; an in-flight op is simply dropped
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q       <= last_d;
`endif
    end
  end

  assign bus_if.req_ready     = req_ready;
  assign bus_if.rsp_valid     = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus_if.rsp_result    = rsp_result_q;
  assign bus_if.rsp_zero      = rsp_zero_q;
  assign bus_if.alu_a         = alu_a_q;
  assign bus_if.alu_b         = alu_b_q;
  assign bus_if.alu_operation = alu_op_q;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: self-checking bench for alu_arb. Provides a reference ALU on the
// shared port, scripts requester traffic, and scores every consumed response
// against expectations queued when the stimulus is issued.
module tb_alu_arb;

  localparam int SIZE = 32;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef struct packed {
    logic [1:0]      valid;
    logic [SIZE-1:0] result;
    logic            zero;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            tb_valid [2];
  logic [SIZE-1:0] tb_a     [2];
  logic [SIZE-1:0] tb_b     [2];
  logic [3:0]      tb_op    [2];
  logic [1:0]      tb_rsp_ready;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   rsp_seen = 0;

  alu_arb_if #(.SIZE(SIZE)) bus_if ();

  alu_arb #(.SIZE(SIZE)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus_if)
  );

  assign bus_if.req_valid = {tb_valid[1], tb_valid[0]};
  assign bus_if.req_a     = {tb_a[1], tb_a[0]};
  assign bus_if.req_b     = {tb_b[1], tb_b[0]};
  assign bus_if.req_op    = {tb_op[1], tb_op[0]};
  assign bus_if.rsp_ready = tb_rsp_ready;

  // Reference ALU on the shared port
  always_comb begin
    case (bus_if.alu_operation)
      OP_AND:  bus_if.alu_result = bus_if.alu_a & bus_if.alu_b;
      OP_OR:   bus_if.alu_result = bus_if.alu_a | bus_if.alu_b;
      OP_ADD:  bus_if.alu_result = bus_if.alu_a + bus_if.alu_b;
      OP_SUB:  bus_if.alu_result = bus_if.alu_a - bus_if.alu_b;
      default: bus_if.alu_result = '0;
    endcase
    bus_if.alu_zero = (bus_if.alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Score each response on the edge where its owner consumes it
  always @(negedge clk) begin
    if (!rst && (bus_if.rsp_valid & bus_if.rsp_ready) != 2'b00) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {62'd0, bus_if.rsp_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_owner",  {62'd0, bus_if.rsp_valid}, {62'd0, e.valid});
        check("rsp_result", {32'd0, bus_if.rsp_result}, {32'd0, e.result});
        check("rsp_zero",   {63'd0, bus_if.rsp_zero}, {63'd0, e.zero});
      end
      rsp_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [1:0] valid, input logic [SIZE-1:0] res, input logic zero);
    exp_t e;
    e.valid = valid; e.result = res; e.zero = zero;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [3:0] op);
    tb_a[i] = a; tb_b[i] = b; tb_op[i] = op; tb_valid[i] = 1'b1;
  endtask

  // Hold requester i valid until its handshake edge, then drop it
  task automatic accept(input int i);
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus_if.req_ready[i]) got = 1;
    end
    if (!got) check($sformatf("hs_timeout_%0d", i), 64'd0, 64'd1);
    @(posedge clk); #1;
    tb_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Single operation from idle with cycle-exact latency checks (RSP_READY = 11)
  task automatic single_op(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                           input logic [3:0] op, input logic [SIZE-1:0] res, input logic zero);
    logic [1:0] oh;
    oh = (i == 1) ? 2'b10 : 2'b01;
    push(oh, res, zero);
    set_req(i, a, b, op);
    @(negedge clk);
    check("so_ready", {62'd0, bus_if.req_ready}, {62'd0, oh});
    @(posedge clk); #1;
    tb_valid[i] = 1'b0;
    check("so_exec_valid", {62'd0, bus_if.rsp_valid}, 64'd0);
    check("so_alu_a",  {32'd0, bus_if.alu_a}, {32'd0, a});
    check("so_alu_b",  {32'd0, bus_if.alu_b}, {32'd0, b});
    check("so_alu_op", {60'd0, bus_if.alu_operation}, {60'd0, op});
    @(posedge clk); #1;
    check("so_resp_valid", {62'd0, bus_if.rsp_valid}, {62'd0, oh});
    @(posedge clk); #1;
    check("so_released", {62'd0, bus_if.rsp_valid}, 64'd0);
  endtask

  initial begin
    int base;
    bit seen;
    rst = 1'b1;
    tb_rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tb_valid[i] = 1'b0; tb_a[i] = '0; tb_b[i] = '0; tb_op[i] = '0;
    end

    // Reset: no grant while reset is high, even with a valid request
    tb_valid[0] = 1'b1;
    tb_a[0] = 32'hDEAD;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_ready", {62'd0, bus_if.req_ready}, 64'd0);
    @(posedge clk); #1;
    check("rst_rsp_valid", {62'd0, bus_if.rsp_valid}, 64'd0);
    check("rst_alu_a",     {32'd0, bus_if.alu_a}, 64'd0);
    check("rst_alu_b",     {32'd0, bus_if.alu_b}, 64'd0);
    check("rst_alu_op",    {60'd0, bus_if.alu_operation}, 64'd0);
    check("rst_result",    {32'd0, bus_if.rsp_result}, 64'd0);
    check("rst_zero",      {63'd0, bus_if.rsp_zero}, 64'd0);
    tb_valid[0] = 1'b0;
    rst = 1'b0;

    // Basic ADD from requester 0, then ALU operands hold while idle
    single_op(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0);
    tb_a[1] = 32'h1234; tb_b[1] = 32'h5678;
    repeat (3) @(posedge clk);
    #1;
    check("hold_alu_a", {32'd0, bus_if.alu_a}, 64'd5);
    check("hold_alu_b", {32'd0, bus_if.alu_b}, 64'd7);

    // After reset, both valid: requester 0 first, then requester 1
    pulse_reset();
    push(2'b01, 32'd0, 1'b1);
    push(2'b10, 32'hFF, 1'b0);
    set_req(0, 32'd9, 32'd9, OP_SUB);
    set_req(1, 32'hF0, 32'h0F, OP_OR);
    fork
      accept(0);
      accept(1);
    join
    drain();

    // Response stall: owner 1 not ready for 5 cycles, non-owner ready ignored
    tb_rsp_ready = 2'b01;
    push(2'b10, 32'd2, 1'b0);
    push(2'b01, 32'd7, 1'b0);
    set_req(1, 32'd1, 32'd1, OP_ADD);
    accept(1);
    set_req(0, 32'd10, 32'd3, OP_SUB);
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (bus_if.rsp_valid[1]) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check("stall_rsp_seen", {63'd0, seen}, 64'd1);
    for (int n = 0; n < 5; n++) begin
      check("stall_valid",  {62'd0, bus_if.rsp_valid}, 64'h2);
      check("stall_result", {32'd0, bus_if.rsp_result}, 64'd2);
      check("stall_ready",  {62'd0, bus_if.req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    tb_rsp_ready = 2'b11;
    @(posedge clk); #1;
    check("stall_released", {62'd0, bus_if.rsp_valid}, 64'd0);
    accept(0);
    drain();

    // Reset during EXEC discards the operation
    set_req(0, 32'd2, 32'd2, OP_ADD);
    accept(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_result", {32'd0, bus_if.rsp_result}, 64'd0);
    for (int n = 0; n < 5; n++) begin
      check("abort_no_rsp", {62'd0, bus_if.rsp_valid}, 64'd0);
      @(posedge clk); #1;
    end
    single_op(1, 32'd3, 32'd4, OP_ADD, 32'd7, 1'b0);

    // Both held valid for four operations
    base = rsp_seen;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) push(2'b01, 32'd42, 1'b0);
`else
    for (int k = 0; k < 2; k++) begin
      push(2'b01, 32'd42, 1'b0);
      push(2'b10, 32'h0F00, 1'b0);
    end
`endif
    set_req(0, 32'd20, 32'd22, OP_ADD);
    set_req(1, 32'hFF00, 32'h0FF0, OP_AND);
    for (int n = 0; n < 60 && rsp_seen < base + 4; n++) begin
      @(posedge clk); #1;
    end
    tb_valid[0] = 1'b0;
    tb_valid[1] = 1'b0;
    check("rr_count", 64'(rsp_seen - base), 64'd4);
    repeat (4) @(posedge clk);
    #1;
    check("rr_no_extra", {62'd0, bus_if.rsp_valid}, 64'd0);
    check("rr_queue", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
